// File: rtl/sbox_arbiter_if.sv
// Bundle of request, issue and result signals between the two S-box requesters,
// the arbiter and the shared 32-bit S-box core.
`ifndef WORD_DATA_WIDTH
`define WORD_DATA_WIDTH 32
`endif

interface sbox_arbiter_if;
  logic [`WORD_DATA_WIDTH-1:0] key_exp_val;
  logic                        key_exp_val_vld;
  logic                        key_exp_gnt;
  logic [`WORD_DATA_WIDTH-1:0] sub_bytes_val;
  logic                        sub_bytes_val_vld;
  logic                        sub_bytes_gnt;
  logic [`WORD_DATA_WIDTH-1:0] sbox_req_data;
  logic                        sbox_req_vld;
  logic [`WORD_DATA_WIDTH-1:0] sbox_rsp_data;
  logic [`WORD_DATA_WIDTH-1:0] key_exp_sbox_data;
  logic                        key_exp_sbox_data_vld;
  logic [`WORD_DATA_WIDTH-1:0] sub_bytes_sbox_data;
  logic                        sub_bytes_sbox_data_vld;
  logic                        sbox_available;

  // Arbiter side
  modport slave (
    input  key_exp_val, key_exp_val_vld, sub_bytes_val, sub_bytes_val_vld, sbox_rsp_data,
    output key_exp_gnt, sub_bytes_gnt, sbox_req_data, sbox_req_vld,
           key_exp_sbox_data, key_exp_sbox_data_vld,
           sub_bytes_sbox_data, sub_bytes_sbox_data_vld, sbox_available
  );

  // Requester / S-box core side
  modport master (
    output key_exp_val, key_exp_val_vld, sub_bytes_val, sub_bytes_val_vld, sbox_rsp_data,
    input  key_exp_gnt, sub_bytes_gnt, sbox_req_data, sbox_req_vld,
           key_exp_sbox_data, key_exp_sbox_data_vld,
           sub_bytes_sbox_data, sub_bytes_sbox_data_vld, sbox_available
  );
endinterface

// File: rtl/sbox_arbiter.sv
// Shares one word-wide S-box core between key expansion and SubBytes.
// Key expansion has fixed priority; SubBytes wins once it has been denied
// MAX_WAIT consecutive cycles. A {valid, owner} tag pipeline follows each
// issued word through the core so the result is routed back to its owner.
`ifndef WORD_DATA_WIDTH
`define WORD_DATA_WIDTH 32
`endif

module sbox_arbiter #(
  parameter int SBOX_LAT = 1,
  parameter int MAX_WAIT = 4
) (
  input logic          clock,
  input logic          reset,
  sbox_arbiter_if.slave bus
);
  localparam int W  = `WORD_DATA_WIDTH;
  localparam int CW = 4;

  // owner encoding in the tag pipeline: 0 = key expansion, 1 = SubBytes
  logic [CW-1:0]   wait_cnt_r;
  logic [SBOX_LAT:0] tag_vld_r;
  logic [SBOX_LAT:0] tag_own_r;
  logic [W-1:0]    req_data_r;
  logic            req_vld_r;
  logic [W-1:0]    ke_data_r;
  logic            ke_vld_r;
  logic [W-1:0]    sb_data_r;
  logic            sb_vld_r;
  logic            avail_r;

  logic            key_gnt_s;
  logic            sub_gnt_s;
  logic            sb_prio_s;
  logic            accept_s;
  logic [W-1:0]    acc_data_s;
  logic [CW-1:0]   wait_nxt_s;
  logic            avail_nxt_s;
  logic            ke_rsp_s;
  logic            sb_rsp_s;

  // Grant selection: key expansion first unless SubBytes has starved long enough
  always_comb begin
    key_gnt_s = 1'b0;
    sub_gnt_s = 1'b0;
    sb_prio_s = (wait_cnt_r == CW'(MAX_WAIT));
    if (reset) begin
      key_gnt_s = 1'b0;
      sub_gnt_s = 1'b0;
    end else if (bus.key_exp_val_vld && bus.sub_bytes_val_vld) begin
      if (sb_prio_s) begin
        sub_gnt_s = 1'b1;
      end else begin
        key_gnt_s = 1'b1;
      end
    end else if (bus.key_exp_val_vld) begin
      key_gnt_s = 1'b1;
    end else if (bus.sub_bytes_val_vld) begin
      sub_gnt_s = 1'b1;
    end else begin
      key_gnt_s = 1'b0;
      sub_gnt_s = 1'b0;
    end
  end

  // Accepted word, starvation counter update and idle indication
  always_comb begin
    accept_s   = key_gnt_s | sub_gnt_s;
    acc_data_s = bus.key_exp_val;
    wait_nxt_s = {CW{1'b0}};
    if (sub_gnt_s) begin
      acc_data_s = bus.sub_bytes_val;
    end else begin
      acc_data_s = bus.key_exp_val;
    end
    if (bus.sub_bytes_val_vld && !sub_gnt_s) begin
      if (wait_cnt_r == CW'(MAX_WAIT)) begin
        wait_nxt_s = wait_cnt_r;
      end else begin
        wait_nxt_s = wait_cnt_r + 4'd1;
      end
    end else begin
      wait_nxt_s = {CW{1'b0}};
    end
    // any live tag (including the one retiring now) keeps the arbiter busy
    avail_nxt_s = !accept_s && !(|tag_vld_r) && !bus.key_exp_val_vld && !bus.sub_bytes_val_vld;
    ke_rsp_s    = tag_vld_r[SBOX_LAT] & ~tag_own_r[SBOX_LAT];
    sb_rsp_s    = tag_vld_r[SBOX_LAT] &  tag_own_r[SBOX_LAT];
  end

  // Issue register, tag pipeline, result routing and idle flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= {CW{1'b0}};
      tag_vld_r  <= {(SBOX_LAT+1){1'b0}};
      tag_own_r  <= {(SBOX_LAT+1){1'b0}};
      req_data_r <= {W{1'b0}};
      req_vld_r  <= 1'b0;
      ke_data_r  <= {W{1'b0}};
      ke_vld_r   <= 1'b0;
      sb_data_r  <= {W{1'b0}};
      sb_vld_r   <= 1'b0;
      avail_r    <= 1'b0;
    end else begin
      wait_cnt_r <= wait_nxt_s;
      tag_vld_r  <= {tag_vld_r[SBOX_LAT-1:0], accept_s};
      tag_own_r  <= {tag_own_r[SBOX_LAT-1:0], sub_gnt_s};
      req_vld_r  <= accept_s;
      if (accept_s) begin
        req_data_r <= acc_data_s;
      end else begin
        req_data_r <= req_data_r;
      end
      ke_vld_r <= ke_rsp_s;
      sb_vld_r <= sb_rsp_s;
      if (ke_rsp_s) begin
        ke_data_r <= bus.sbox_rsp_data;
      end else begin
        ke_data_r <= ke_data_r;
      end
      if (sb_rsp_s) begin
        sb_data_r <= bus.sbox_rsp_data;
      end else begin
        sb_data_r <= sb_data_r;
      end
      avail_r <= avail_nxt_s;
    end
  end

  assign bus.key_exp_gnt             = key_gnt_s;
  assign bus.sub_bytes_gnt           = sub_gnt_s;
  assign bus.sbox_req_data           = req_data_r;
  assign bus.sbox_req_vld            = req_vld_r;
  assign bus.key_exp_sbox_data       = ke_data_r;
  assign bus.key_exp_sbox_data_vld   = ke_vld_r;
  assign bus.sub_bytes_sbox_data     = sb_data_r;
  assign bus.sub_bytes_sbox_data_vld = sb_vld_r;
  assign bus.sbox_available          = avail_r;
endmodule

// File: doc/sbox_arbiter.md
Name: sbox_arbiter

Overview:
Shares one 32-bit word S-box datapath (4 parallel byte S-boxes, fixed pipeline latency) between two requesters: the key-expansion engine and the SubBytes round stage.
- Accepts at most one word per cycle.
- Issues the word to the S-box core and tracks which requester owns each in-flight word.
- Routes each result back to its owner.
- Fixed priority goes to key expansion, with an anti-starvation override for SubBytes.
- Sits between the round controller/key scheduler and the S-box core.

Parameters:
SBOX_LAT, 1, cycles from sbox_req_vld to valid sbox_rsp_data (1..4)
MAX_WAIT, 4, consecutive cycles SubBytes may be denied before it takes priority (1..15)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
key_exp_val  in  `WORD_DATA_WIDTH  word to substitute, key-expansion requester
key_exp_val_vld  in  1  key-expansion request valid
key_exp_gnt  out  1  key-expansion request accepted this cycle
sub_bytes_val  in  `WORD_DATA_WIDTH  word to substitute, SubBytes requester
sub_bytes_val_vld  in  1  SubBytes request valid
sub_bytes_gnt  out  1  SubBytes request accepted this cycle
sbox_req_data  out  `WORD_DATA_WIDTH  word issued to S-box core
sbox_req_vld  out  1  issue strobe to S-box core
sbox_rsp_data  in  `WORD_DATA_WIDTH  S-box core result, valid SBOX_LAT cycles after issue
key_exp_sbox_data  out  `WORD_DATA_WIDTH  substituted word for key expansion
key_exp_sbox_data_vld  out  1  key_exp_sbox_data valid (1-cycle pulse)
sub_bytes_sbox_data  out  `WORD_DATA_WIDTH  substituted word for SubBytes
sub_bytes_sbox_data_vld  out  1  sub_bytes_sbox_data valid (1-cycle pulse)
sbox_available  out  1  arbiter idle: nothing in flight, no request pending

Behaviour:
Reset values:
- All outputs are 0 while reset is high, including data buses and sbox_available.
- The tag pipeline and wait counter clear.

Handshake:
- A requester holds vld and val stable until it sees its gnt.
- Acceptance is vld & gnt at a posedge.
- gnt is combinational from the vld inputs and wait counter, and is 0 during reset.
- key_exp_gnt and sub_bytes_gnt are never both 1 in the same cycle.
- gnt=1 only when the matching vld=1.

Arbitration:
- Only key_exp_val_vld set: key expansion is granted.
- Only sub_bytes_val_vld set: SubBytes is granted.
- Both set: key expansion is granted unless wait_cnt == MAX_WAIT, in which case SubBytes is granted.
- wait_cnt increments, saturating at MAX_WAIT, each cycle sub_bytes_val_vld=1 and sub_bytes_gnt=0.
- wait_cnt clears on a SubBytes grant or when sub_bytes_val_vld=0.

Issue and latency:
- An accept in cycle N registers sbox_req_data and sbox_req_vld=1 in cycle N+1. sbox_req_vld is otherwise 0, and sbox_req_data holds its last value.
- A tag pipeline of depth SBOX_LAT+1 carries {valid, owner}.
- The result is registered into the owner's data output with its vld=1 in cycle N+2+SBOX_LAT. Total latency is SBOX_LAT+2 (3 at default).
- The non-owner's vld stays 0 and its data holds.

Throughput:
- Back-to-back accepts every cycle.
- Results return in accept order.
- Interleaved owners are routed correctly.

sbox_available:
- Registered.
- Next value is 1 iff no accept occurs this cycle, no tag-pipeline entry is valid after this edge, and neither vld input is high.
- Goes to 1 on the first posedge after reset deassertion when idle.

Reset mid-operation:
- All in-flight tags are discarded.
- No data_vld pulses from pre-reset requests occur after reset deassertion.

Test Plan:
- Single key-exp request: key_exp_val=0x53FF0000 in cycle 0 -> key_exp_gnt=1 in cycle 0; sbox_req_vld with 0x53FF0000 in cycle 1; key_exp_sbox_data=0xED166363 with vld in cycle 3; sub_bytes_sbox_data_vld stays 0; sbox_available 0 in cycles 1-3 and 1 again in cycle 4.
- Single SubBytes request: sub_bytes_val=0x00010253 -> sub_bytes_sbox_data=0x637C77ED with vld 3 cycles after grant.
- Contention, MAX_WAIT=4: both vld held continuously with a new key-exp word after each grant -> key-exp granted cycles 0-3, SubBytes granted cycle 4, wait_cnt back to 0, key-exp granted cycle 5.
- Back-to-back interleave: accepts KE(0x00000000), SB(0xFFFFFFFF), KE(0x01010101) in cycles 0,1,2 -> KE result 0x63636363 in cycle 3, SB result 0x16161616 in cycle 4, KE result 0x7C7C7C7C in cycle 5; never both gnt.
- Reset mid-flight: accept in cycle 0, assert reset in cycle 1 for 1 cycle -> all outputs 0 during reset; no data_vld afterwards; sbox_available=1 one cycle after release.
- SBOX_LAT=3 build: single request -> result vld exactly 5 cycles after grant.
